// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared word type, tag layout and owner encodings for the memory port arbiter
package mem_port_arbiter_pkg;

  localparam int REG_SIZE = 32;
  typedef logic [REG_SIZE-1:0] word_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  typedef struct packed {
    logic valid;
    logic is_dm;
    logic is_store;
  } tag_t;

  localparam tag_t TAG_NONE = '0;

  // A redirect kills fetch tags only; data tags always complete.
  function automatic tag_t flush_mask(tag_t t, logic flush_if);
    tag_t r;
    r = t;
    if (flush_if && (t.is_dm == OWN_IF)) r.valid = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_tag_pipe.sv
// rtl/mem_port_arbiter_tag_pipe.sv - in-flight access tags, one stage per memory latency cycle
module arb_tag_pipe
  import mem_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  tag_t issue_tag,
  input  logic clear_if,
  output tag_t last_tag
);

  tag_t stage [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= TAG_NONE;
    end else begin
      stage[0] <= flush_mask(issue_tag, clear_if);
      for (int i = 1; i < DEPTH; i++) stage[i] <= flush_mask(stage[i-1], clear_if);
    end
  end

  assign last_tag = stage[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between fetch and data requesters
// Optional starvation guard for fetch enabled with ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_resp_valid,
  output logic [31:0] if_resp_data,
  input  logic        dm_req_valid,
  output logic        dm_req_ready,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_we,
  output logic        dm_resp_valid,
  output logic [31:0] dm_resp_data,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_we,
  input  logic [31:0] mem_rdata
);

  logic force_if;
  logic grant_if;
  logic grant_dm;
  tag_t issue_tag;
  tag_t last_tag;
  tag_t done_tag;

  // Readies are held low in reset so no handshake can slip in.
  assign dm_req_ready = rst && !force_if;
  assign if_req_ready = rst && (!dm_req_valid || force_if);
  assign grant_dm     = dm_req_valid && dm_req_ready;
  assign grant_if     = if_req_valid && if_req_ready;

`ifdef ARB_STARVE_GUARD_EN
  logic [2:0] starve_cnt;

  assign force_if = if_req_valid && (starve_cnt >= 3'(STARVE_LIMIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (grant_if || !if_req_valid) begin
      starve_cnt <= '0;
    end else if (grant_dm) begin
      starve_cnt <= starve_cnt + 3'd1;
    end
  end
`else
  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT != 0);
  assign force_if = 1'b0;
`endif

  always_comb begin
    mem_en    = grant_if || grant_dm;
    mem_addr  = '0;
    mem_we    = '0;
    mem_wdata = '0;
    if (grant_dm) begin
      mem_addr  = {dm_addr[31:2], 2'b00};
      mem_we    = dm_we;
      mem_wdata = dm_wdata;
    end else if (grant_if) begin
      mem_addr  = {if_addr[31:2], 2'b00};
    end
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[1:0], dm_addr[1:0]};

  always_comb begin
    issue_tag          = TAG_NONE;
    issue_tag.valid    = grant_if || grant_dm;
    issue_tag.is_dm    = grant_dm ? OWN_DM : OWN_IF;
    issue_tag.is_store = grant_dm && (dm_we != 4'b0000);
  end

  arb_tag_pipe #(
    .DEPTH(MEM_LATENCY)
  ) u_tag_pipe (
    .clk      (clk),
    .rst      (rst),
    .issue_tag(issue_tag),
    .clear_if (if_flush),
    .last_tag (last_tag)
  );

  // The tag leaving the pipe is still in flight, so a flush this cycle squashes it too.
  assign done_tag = flush_mask(last_tag, if_flush);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_resp_valid <= 1'b0;
      if_resp_data  <= '0;
      dm_resp_valid <= 1'b0;
      dm_resp_data  <= '0;
    end else begin
      if_resp_valid <= done_tag.valid && (done_tag.is_dm == OWN_IF);
      if_resp_data  <= (done_tag.valid && (done_tag.is_dm == OWN_IF)) ? mem_rdata : '0;
      dm_resp_valid <= done_tag.valid && (done_tag.is_dm == OWN_DM);
      dm_resp_data  <= (done_tag.valid && (done_tag.is_dm == OWN_DM) && !done_tag.is_store)
                       ? mem_rdata : '0;
    end
  end

endmodule
